// File: rtl/pipe_wb_commit.sv
// rtl/pipe_wb_commit.sv - multi-lane writeback stage with youngest-writer arbitration and retire counter
// Lane 0 is the oldest instruction; a younger lane writing the same index suppresses the older write.
module pipe_wb_commit #(
  parameter int ISSUE_NUM = 2,
  parameter int XLEN      = 64,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_wb,
  input  logic                        flush_wb,
  input  logic [ISSUE_NUM-1:0]        in_valid,
  input  logic [ISSUE_NUM-1:0]        in_rd_en,
  input  logic [ISSUE_NUM*REG_AW-1:0] in_rd,
  input  logic [ISSUE_NUM*XLEN-1:0]   in_res,
  output logic [ISSUE_NUM-1:0]        wb_rd_en,
  output logic [ISSUE_NUM*REG_AW-1:0] wb_rd,
  output logic [ISSUE_NUM*XLEN-1:0]   wb_res,
  output logic [ISSUE_NUM-1:0]        wb_valid,
  output logic [CNT_W-1:0]            instret
);

  logic [ISSUE_NUM-1:0]        reg_valid;
  logic [ISSUE_NUM-1:0]        reg_rd_en;
  logic [ISSUE_NUM*REG_AW-1:0] reg_rd;
  logic [ISSUE_NUM*XLEN-1:0]   reg_res;
  logic [ISSUE_NUM-1:0]        killed;
  logic [CNT_W-1:0]            retire_cnt;

  always_ff @(posedge clk) begin
    if (rst || flush_wb) begin
      reg_valid <= '0;
      reg_rd_en <= '0;
      reg_rd    <= '0;
      reg_res   <= '0;
    end else if (!stall_wb) begin
      reg_valid <= in_valid;
      reg_rd_en <= in_rd_en;
      reg_rd    <= in_rd;
      reg_res   <= in_res;
    end
  end

  // An older lane is killed when any younger valid lane targets the same index.
  always_comb begin
    killed = '0;
    for (int i = 0; i < ISSUE_NUM; i++) begin
      for (int j = i + 1; j < ISSUE_NUM; j++) begin
        if (reg_valid[j] && reg_rd_en[j] &&
            (reg_rd[j*REG_AW +: REG_AW] == reg_rd[i*REG_AW +: REG_AW]))
          killed[i] = 1'b1;
      end
    end
  end

  always_comb begin
    wb_valid = reg_valid & {ISSUE_NUM{~stall_wb}};
    wb_rd_en = '0;
    for (int i = 0; i < ISSUE_NUM; i++) begin
      wb_rd_en[i] = wb_valid[i] && reg_rd_en[i] &&
                    (reg_rd[i*REG_AW +: REG_AW] != '0) && !killed[i];
    end
  end

  assign wb_rd  = reg_rd;
  assign wb_res = reg_res;

  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < ISSUE_NUM; i++)
      retire_cnt = retire_cnt + CNT_W'(wb_valid[i]);
  end

  always_ff @(posedge clk) begin
    if (rst)
      instret <= '0;
    else
      instret <= instret + retire_cnt;
  end

endmodule

// File: tb/tb_pipe_wb_commit.sv
// tb/tb_pipe_wb_commit.sv - directed bench for pipe_wb_commit with a per-cycle reference model
module tb_pipe_wb_commit;
  localparam int N  = 2;
  localparam int XL = 64;
  localparam int AW = 5;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst, stall_wb, flush_wb;
  logic [N-1:0]    in_valid, in_rd_en;
  logic [N*AW-1:0] in_rd;
  logic [N*XL-1:0] in_res;
  logic [N-1:0]    wb_rd_en, wb_valid;
  logic [N*AW-1:0] wb_rd;
  logic [N*XL-1:0] wb_res;
  logic [CW-1:0]   instret;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit check_en = 1'b0;

  pipe_wb_commit #(.ISSUE_NUM(N), .XLEN(XL), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall_wb(stall_wb), .flush_wb(flush_wb),
    .in_valid(in_valid), .in_rd_en(in_rd_en), .in_rd(in_rd), .in_res(in_res),
    .wb_rd_en(wb_rd_en), .wb_rd(wb_rd), .wb_res(wb_res), .wb_valid(wb_valid),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: what each lane holds and how many instructions have retired.
  logic        m_v [N];
  logic        m_en[N];
  logic [4:0]  m_rd[N];
  logic [63:0] m_res[N];
  int          m_cnt = 0;

  initial for (int i = 0; i < N; i++) begin
    m_v[i] = 0; m_en[i] = 0; m_rd[i] = 0; m_res[i] = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
      for (int i = 0; i < N; i++) begin m_v[i] = 0; m_en[i] = 0; m_rd[i] = 0; m_res[i] = 0; end
    end else begin
      if (!stall_wb)
        for (int i = 0; i < N; i++) m_cnt += m_v[i] ? 1 : 0;
      m_cnt = m_cnt % 16;
      if (flush_wb) begin
        for (int i = 0; i < N; i++) begin m_v[i] = 0; m_en[i] = 0; m_rd[i] = 0; m_res[i] = 0; end
      end else if (!stall_wb) begin
        for (int i = 0; i < N; i++) begin
          m_v[i] = in_valid[i]; m_en[i] = in_rd_en[i];
          m_rd[i] = in_rd[i*AW +: AW]; m_res[i] = in_res[i*XL +: XL];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      int last_writer[32];
      logic [N-1:0]    e_valid, e_en;
      logic [N*AW-1:0] e_rd;
      logic [N*XL-1:0] e_res;
      for (int r = 0; r < 32; r++) last_writer[r] = -1;
      for (int i = 0; i < N; i++) if (m_v[i] && m_en[i]) last_writer[m_rd[i]] = i;
      for (int i = 0; i < N; i++) begin
        e_valid[i] = m_v[i] && !stall_wb;
        e_en[i] = e_valid[i] && m_en[i] && (m_rd[i] != 0) && (last_writer[m_rd[i]] == i);
        e_rd[i*AW +: AW] = m_rd[i];
        e_res[i*XL +: XL] = m_res[i];
      end
      chk("model_wb_valid", 128'(wb_valid), 128'(e_valid));
      chk("model_wb_rd_en", 128'(wb_rd_en), 128'(e_en));
      chk("model_wb_rd", 128'(wb_rd), 128'(e_rd));
      chk("model_wb_res", 128'(wb_res), 128'(e_res));
      chk("model_instret", 128'(instret), 128'(m_cnt));
    end
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] en, input logic [4:0] rd0,
                       input logic [4:0] rd1, input logic [63:0] r0, input logic [63:0] r1,
                       input logic st, input logic fl, input logic rs);
    in_valid = v; in_rd_en = en; in_rd = {rd1, rd0}; in_res = {r1, r0};
    stall_wb = st; flush_wb = fl; rst = rs;
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    drive(2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check_en = 1'b1;
    chk("reset_instret", 128'(instret), 128'd0);
    chk("reset_wb_valid", 128'(wb_valid), 128'd0);
    chk("reset_wb_res", 128'(wb_res), 128'd0);
    tick();

    // basic dual write
    drive(2'b11, 2'b11, 5'd3, 5'd4, 64'hAA, 64'hBB, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("basic_rd_en", 128'(wb_rd_en), 128'h3);
    chk("basic_rd", 128'(wb_rd), 128'({5'd4, 5'd3}));
    chk("basic_res1", 128'(wb_res[127:64]), 128'hBB);
    chk("basic_res0", 128'(wb_res[63:0]), 128'hAA);
    tick();
    chk("basic_instret", 128'(instret), 128'd2);

    // same destination on both lanes
    drive(2'b11, 2'b11, 5'd7, 5'd7, 64'h11, 64'h22, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("collide_rd_en", 128'(wb_rd_en), 128'h2);
    tick();
    chk("collide_instret", 128'(instret), 128'd4);

    // x0 destination
    drive(2'b01, 2'b01, 5'd0, 5'd0, 64'h5, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("x0_valid", 128'(wb_valid), 128'h1);
    chk("x0_rd_en", 128'(wb_rd_en), 128'h0);
    tick();
    chk("x0_instret", 128'(instret), 128'd5);

    // invalid lane with rd_en set
    drive(2'b00, 2'b11, 5'd8, 5'd9, 64'h1, 64'h2, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("inval_rd_en", 128'(wb_rd_en), 128'h0);
    tick();
    chk("inval_instret", 128'(instret), 128'd5);

    // stall hold for three cycles
    drive(2'b01, 2'b01, 5'd9, 5'd0, 64'h77, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 2'b11, 5'(12 + k), 5'(20 + k), 64'(1000 + k), 64'(2000 + k), 1'b1, 1'b0, 1'b0);
      chk("stall_rd_en", 128'(wb_rd_en), 128'h0);
      chk("stall_res0", 128'(wb_res[63:0]), 128'h77);
      tick();
      chk("stall_instret", 128'(instret), 128'd5);
    end
    drive(2'b11, 2'b11, 5'd1, 5'd2, 64'h100, 64'h200, 1'b0, 1'b0, 1'b0);
    chk("release_rd_en", 128'(wb_rd_en), 128'h1);
    chk("release_rd0", 128'(wb_rd[4:0]), 128'd9);
    chk("release_res0", 128'(wb_res[63:0]), 128'h77);
    tick();
    chk("release_instret", 128'(instret), 128'd6);
    idle();
    chk("captured_rd_en", 128'(wb_rd_en), 128'h3);
    chk("captured_res0", 128'(wb_res[63:0]), 128'h100);
    tick();
    chk("captured_instret", 128'(instret), 128'd8);

    // flush together with stall discards the held contents
    drive(2'b11, 2'b11, 5'd5, 5'd6, 64'h55, 64'h66, 1'b0, 1'b0, 1'b0);
    tick();
    drive(2'b11, 2'b11, 5'd10, 5'd11, 64'h1, 64'h2, 1'b1, 1'b1, 1'b0);
    chk("flst_valid", 128'(wb_valid), 128'h0);
    tick();
    chk("flst_instret", 128'(instret), 128'd8);
    idle();
    chk("flst_after_valid", 128'(wb_valid), 128'h0);
    tick();

    // flush alone still retires the current contents
    drive(2'b11, 2'b11, 5'd5, 5'd6, 64'h55, 64'h66, 1'b0, 1'b0, 1'b0);
    tick();
    drive(2'b11, 2'b11, 5'd10, 5'd11, 64'h1, 64'h2, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", 128'(wb_valid), 128'h3);
    chk("flush_rd_en", 128'(wb_rd_en), 128'h3);
    tick();
    chk("flush_instret", 128'(instret), 128'd10);
    idle();
    chk("flush_after_valid", 128'(wb_valid), 128'h0);
    tick();

    // counter wrap: 9 cycles of 2 retirements from zero
    drive(2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("wrap_start", 128'(instret), 128'd0);
    for (int k = 0; k < 9; k++) begin
      drive(2'b11, 2'b11, 5'(k + 1), 5'(k + 17), 64'(k), 64'(k + 100), 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
    tick();
    chk("wrap_instret", 128'(instret), 128'd2);

    // reset during a stall discards everything
    drive(2'b11, 2'b11, 5'd3, 5'd4, 64'hDEAD, 64'hBEEF, 1'b0, 1'b0, 1'b0);
    tick();
    drive(2'b11, 2'b11, 5'd3, 5'd4, 64'h1, 64'h2, 1'b1, 1'b0, 1'b1);
    tick();
    chk("rst_valid", 128'(wb_valid), 128'h0);
    chk("rst_rd_en", 128'(wb_rd_en), 128'h0);
    chk("rst_rd", 128'(wb_rd), 128'h0);
    chk("rst_res", 128'(wb_res), 128'h0);
    chk("rst_instret", 128'(instret), 128'd0);
    drive(2'b10, 2'b10, 5'd0, 5'd15, 64'h0, 64'h99, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    chk("first_load_rd_en", 128'(wb_rd_en), 128'h2);
    tick();
    chk("first_load_instret", 128'(instret), 128'd1);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/pipe_wb_commit.md
PIPE_WB_COMMIT -- requirements
Module: pipe_wb_commit

Interface
REQ-001 Parameter ISSUE_NUM, default 2, number of writeback lanes; lane 0 is the oldest instruction.
REQ-002 Parameter XLEN, default 64, result data width.
REQ-003 Parameter REG_AW, default 5, register index width.
REQ-004 Parameter CNT_W, default 64, retired-instruction counter width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 stall_wb  input  1  holds the WB stage register and blocks register-file writes this cycle.
REQ-008 flush_wb  input  1  discards incoming lanes; stage register loads invalid.
REQ-009 in_valid  input  ISSUE_NUM  per-lane instruction valid from the previous stage.
REQ-010 in_rd_en  input  ISSUE_NUM  per-lane destination write request.
REQ-011 in_rd  input  ISSUE_NUM*REG_AW  per-lane destination index; lane i occupies bits [i*REG_AW +: REG_AW].
REQ-012 in_res  input  ISSUE_NUM*XLEN  per-lane result, packed the same way.
REQ-013 wb_rd_en  output  ISSUE_NUM  per-lane register-file write enable.
REQ-014 wb_rd  output  ISSUE_NUM*REG_AW  per-lane write index.
REQ-015 wb_res  output  ISSUE_NUM*XLEN  per-lane write data.
REQ-016 wb_valid  output  ISSUE_NUM  per-lane instruction retiring this cycle.
REQ-017 instret  output  CNT_W  count of retired instructions.

Function
REQ-018 Stage register per lane holds valid, rd_en, rd and res.
REQ-019 Stage register update priority: rst > flush_wb > stall_wb > load.
REQ-020 On flush_wb=1 without rst, all lanes load valid=0 and rd_en=0; rd and res load 0.
REQ-021 On stall_wb=1 with flush_wb=0, all stage-register fields hold their values.
REQ-022 On load, each lane captures in_valid, in_rd_en, in_rd and in_res unchanged.
REQ-023 wb_valid[i] = reg_valid[i] AND NOT stall_wb; this is combinational from the register.
REQ-024 wb_rd_en[i] = wb_valid[i] AND reg_rd_en[i] AND (reg_rd[i] != 0) AND NOT killed[i].
REQ-025 killed[i] is set when some younger lane j>i has reg_valid[j], reg_rd_en[j] and reg_rd[j]==reg_rd[i]; only the youngest writer of an index is enabled.
REQ-026 wb_rd and wb_res are driven directly from the stage register regardless of enable.
REQ-027 Latency: an input accepted at edge N appears on the outputs during cycle N+1, and during each later cycle until the first cycle with stall_wb=0.
REQ-028 instret increments at each rising edge by popcount(wb_valid) and wraps modulo 2^CNT_W without saturating.
REQ-029 With flush_wb=1 and stall_wb=0, the current register contents still retire (wb_valid and instret); only the incoming lanes are dropped.
REQ-030 With flush_wb=1 and stall_wb=1, the current contents are discarded without retiring or writing.
REQ-031 A lane with in_valid=0 and in_rd_en=1 never writes and never counts.

Reset
REQ-032 When rst=1 at an edge: all reg_valid, reg_rd_en, reg_rd and reg_res are 0, and instret is 0.
REQ-033 While rst=1, wb_valid=0, wb_rd_en=0, wb_rd=0 and wb_res=0 from the first edge onward.
REQ-034 rst applied mid-stall discards the held contents; nothing retires.
REQ-035 The first load occurs at the first edge with rst=0.

Verification
REQ-036 Basic: ISSUE_NUM=2, lane0 {v=1,en=1,rd=3,res=0xAA}, lane1 {v=1,en=1,rd=4,res=0xBB}, no stall -> next cycle both wb_rd_en=1 with those values, and instret goes 0->2.
REQ-037 Same-rd collision: both lanes rd=7, res 0x11 / 0x22 -> wb_rd_en=2'b10 (only 0x22 written), and instret +2.
REQ-038 x0 suppression: lane0 {v=1,en=1,rd=0,res=0x5} -> wb_valid[0]=1, wb_rd_en[0]=0, and instret +1.
REQ-039 Stall hold: load {rd=9,res=0x77}, then stall_wb=1 for 3 cycles with changing inputs -> wb_rd_en=0 and instret unchanged during the stall; after release, one write of 0x77 to rd 9, instret +1, and new inputs captured.
REQ-040 Flush priority: stall_wb=1 and flush_wb=1 together with a valid register -> no write, no count, and next cycle wb_valid=0; flush_wb=1 alone -> current contents retire, next cycle invalid.
REQ-041 Wrap and reset: preset CNT_W=4, retire 2 lanes per cycle for 9 cycles -> instret=2 (18 mod 16); assert rst mid-stream -> all outputs and instret are 0 at the next edge.
